// File: rtl/ram_burst_pkg.sv
// Shared opcodes, FSM state type and field widths for the command-driven burst RAM.
package ram_burst_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_WADDR = 2'b00;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
  localparam logic [OP_W-1:0] OP_RADDR = 2'b10;
  localparam logic [OP_W-1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ram_burst_if.sv
// Command-in / read-data-out bus between the SPI word deserialiser and ram_burst.
interface ram_burst_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH+1:0] din;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  err;

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, err
  );

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, err
  );

endinterface

// File: rtl/ram_sp_array.sv
// Single-port storage: synchronous write, registered read, no reset (block-RAM friendly).
module ram_sp_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Array access; the caller only enables in-range addresses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata <= mem_r[addr];
      end
    end
  end

endmodule

// File: rtl/ram_burst.sv
// Command-driven RAM with write/read pointers and a valid/ready read-return path.
// Optional pointer auto-increment for bursts is enabled by defining RAM_AUTO_INC_EN.
module ram_burst
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic           clk,
  input  logic           rst,
  ram_burst_if.slave     bus
);

  state_e                state_r;
  logic                  rx_ready_r;
  logic                  tx_valid_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;

  logic                  consume_s;
  logic [OP_W-1:0]       op_s;
  logic [DATA_WIDTH-1:0] field_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  arr_en_s;
  logic                  arr_we_s;
  logic [ADDR_WIDTH-1:0] arr_addr_s;
  logic [DATA_WIDTH-1:0] arr_rdata_s;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] p);
    return (32'(p) < 32'(MEM_DEPTH));
  endfunction

`ifdef RAM_AUTO_INC_EN
  // Out-of-range pointers also land on 0, so a burst always restarts inside the array.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    if (32'(p) >= 32'(MEM_DEPTH - 1)) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return p + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction
`endif

  assign consume_s = bus.rx_valid && rx_ready_r;
  assign op_s      = bus.din[DATA_WIDTH+1:DATA_WIDTH];
  assign field_s   = bus.din[DATA_WIDTH-1:0];
  assign addr_s    = field_s[ADDR_WIDTH-1:0];
  assign wr_ok_s   = in_range(wr_ptr_r);
  assign rd_ok_s   = in_range(rd_ptr_r);

  // Array port steering: the read is launched at the consuming edge so RD can register it.
  always_comb begin
    arr_en_s   = 1'b0;
    arr_we_s   = 1'b0;
    arr_addr_s = rd_ptr_r;
    if (consume_s && !rst) begin
      case (op_s)
        OP_WRITE: begin
          arr_en_s   = wr_ok_s;
          arr_we_s   = 1'b1;
          arr_addr_s = wr_ptr_r;
        end
        OP_READ:  arr_en_s = rd_ok_s;
        default:  arr_en_s = 1'b0;
      endcase
    end else begin
      arr_en_s = 1'b0;
    end
  end

  ram_sp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en_s),
    .we    (arr_we_s),
    .addr  (arr_addr_s),
    .wdata (field_s),
    .rdata (arr_rdata_s)
  );

  // Command FSM, pointers, range error and read-return handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rx_ready_r <= 1'b1;
      tx_valid_r <= 1'b0;
      err_r      <= 1'b0;
      dout_r     <= {DATA_WIDTH{1'b0}};
      wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (consume_s) begin
            case (op_s)
              OP_WADDR: wr_ptr_r <= addr_s;
              OP_WRITE: begin
                err_r <= !wr_ok_s;
`ifdef RAM_AUTO_INC_EN
                wr_ptr_r <= ptr_inc(wr_ptr_r);
`endif
              end
              OP_RADDR: rd_ptr_r <= addr_s;
              OP_READ: begin
                state_r    <= RD;
                rx_ready_r <= 1'b0;
              end
              default: err_r <= 1'b0;
            endcase
          end
        end
        RD: begin
          dout_r     <= rd_ok_s ? arr_rdata_s : {DATA_WIDTH{1'b0}};
          tx_valid_r <= 1'b1;
          err_r      <= !rd_ok_s;
          state_r    <= HOLD;
`ifdef RAM_AUTO_INC_EN
          rd_ptr_r   <= ptr_inc(rd_ptr_r);
`endif
        end
        HOLD: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            rx_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          rx_ready_r <= 1'b1;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.dout     = dout_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_ram_burst.sv
// Directed bench for ram_burst (MEM_DEPTH=200 so out-of-range pointers are reachable);
// the burst section follows RAM_AUTO_INC_EN.
module tb_ram_burst;
  import ram_burst_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  ram_burst_if #(.DATA_WIDTH(DW)) bus ();

  ram_burst #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the consuming edge.
  task automatic send(input logic [1:0] op, input logic [7:0] field);
    int n = 0;
    while (!bus.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("rx_ready_wait", bus.rx_ready, 1'b1);
    bus.din      = {op, field};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // READ with tx_ready high: valid one cycle after consumption, gone the cycle after.
  task automatic do_read(input string tag, input logic [7:0] exp, input logic exp_err);
    send(OP_READ, 8'h00);
    check({tag, "_busy"}, bus.rx_ready, 1'b0);
    check({tag, "_notyet"}, bus.tx_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, bus.tx_valid, 1'b1);
    check({tag, "_dout"}, bus.dout, exp);
    check({tag, "_err"}, bus.err, exp_err);
    @(negedge clk);
    check({tag, "_drop"}, bus.tx_valid, 1'b0);
    check({tag, "_ready"}, bus.rx_ready, 1'b1);
    check({tag, "_errclr"}, bus.err, 1'b0);
  endtask

  initial begin
    bus.din      = 10'h000;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_rx_ready", bus.rx_ready, 1'b1);
    rst = 1'b0;

    // Basic write then read back
    send(OP_WADDR, 8'h10);
    send(OP_WRITE, 8'hA5);
    check("write_no_err", bus.err, 1'b0);
    send(OP_RADDR, 8'h10);
    do_read("basic", 8'hA5, 1'b0);

    // Backpressure: dout held, extra word not consumed until IDLE
    send(OP_WADDR, 8'h20);
    send(OP_WRITE, 8'h3C);
    send(OP_RADDR, 8'h20);
    bus.tx_ready = 1'b0;
    send(OP_READ, 8'h00);
    @(negedge clk);
    check("bp_valid", bus.tx_valid, 1'b1);
    check("bp_dout", bus.dout, 8'h3C);
    bus.din      = {OP_WADDR, 8'h30};
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.tx_valid, 1'b1);
      check("bp_hold_dout", bus.dout, 8'h3C);
      check("bp_hold_busy", bus.rx_ready, 1'b0);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", bus.tx_valid, 1'b0);
    check("bp_release_ready", bus.rx_ready, 1'b1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    send(OP_WRITE, 8'h77);
    send(OP_RADDR, 8'h30);
    do_read("held_word", 8'h77, 1'b0);

`ifdef RAM_AUTO_INC_EN
    // Burst across the top of the array wraps to address 0
    send(OP_WADDR, 8'(DEPTH - 1));
    send(OP_WRITE, 8'h11);
    send(OP_WRITE, 8'h22);
    send(OP_RADDR, 8'(DEPTH - 1));
    do_read("inc_top", 8'h11, 1'b0);
    do_read("inc_wrap", 8'h22, 1'b0);
`else
    // Pointers stay put without auto-increment
    send(OP_WADDR, 8'h40);
    send(OP_WRITE, 8'h11);
    send(OP_WRITE, 8'h22);
    send(OP_RADDR, 8'h40);
    do_read("noinc_a", 8'h22, 1'b0);
    do_read("noinc_b", 8'h22, 1'b0);
`endif

    // Out-of-range write dropped with err pulse, out-of-range read returns 0
    send(OP_WADDR, 8'd50);
    send(OP_WRITE, 8'h44);
    send(OP_WADDR, 8'd250);
    send(OP_WRITE, 8'h33);
    check("oor_wr_err", bus.err, 1'b1);
    @(negedge clk);
    check("oor_wr_err_pulse", bus.err, 1'b0);
    send(OP_RADDR, 8'd250);
    do_read("oor_rd", 8'h00, 1'b1);
    send(OP_RADDR, 8'd50);
    do_read("oor_mem_intact", 8'h44, 1'b0);

    // Reset during HOLD
    bus.tx_ready = 1'b0;
    send(OP_RADDR, 8'h10);
    send(OP_READ, 8'h00);
    @(negedge clk);
    check("hold_valid", bus.tx_valid, 1'b1);
    check("hold_dout", bus.dout, 8'hA5);
    rst = 1'b1;
    @(negedge clk);
    check("hold_rst_valid", bus.tx_valid, 1'b0);
    check("hold_rst_ready", bus.rx_ready, 1'b1);
    check("hold_rst_dout", bus.dout, 8'h00);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    send(OP_WRITE, 8'h66);
    do_read("ptr_reset", 8'h66, 1'b0);
    send(OP_RADDR, 8'h10);
    do_read("mem_retained", 8'hA5, 1'b0);

    // Read-after-write on consecutive edges
    send(OP_WADDR, 8'h50);
    send(OP_RADDR, 8'h50);
    send(OP_WRITE, 8'h5A);
    do_read("raw", 8'h5A, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
